// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// It retires two multiplier bits per cycle and supports signed and unsigned operands per operation.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int SW = $clog2(N);
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        mcand_q, mcand_d;
    logic [EW-1:0]        mul_q, mul_d;
    logic                 qm1_q, qm1_d;
    logic [SW-1:0]        step_q, step_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [AW-1:0]        addend;
    logic [AW-1:0]        acc_sum;
    logic [AW+EW:0]       shifted;
    logic                 a_sign;
    logic                 b_sign;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mul_d     = mul_q;
        qm1_d     = qm1_q;
        step_d    = step_q;
        product_d = product_q;
        a_sign    = is_signed & a[WIDTH-1];
        b_sign    = is_signed & b[WIDTH-1];

        case ({mul_q[1:0], qm1_q})
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = {mcand_q[AW-2:0], 1'b0};
            3'b100:         addend = -{mcand_q[AW-2:0], 1'b0};
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
        acc_sum = acc_q + addend;
        shifted = $signed({acc_sum, mul_q, qm1_q}) >>> 2;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    mcand_d = {{4{a_sign}}, a};
                    mul_d   = {{2{b_sign}}, b};
                    qm1_d   = 1'b0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                {acc_d, mul_d, qm1_d} = shifted;
                step_d = step_q + SW'(1);
                if (step_q == SW'(N - 1)) begin
                    // Bits [2W:1] of the shifted register are the low half of {acc, mul}.
                    product_d = shifted[2*WIDTH:1];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments; reset clears the whole datapath.
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mul_q     <= '0;
            qm1_q     <= 1'b0;
            step_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mul_q     <= mul_d;
            qm1_q     <= qm1_d;
            step_q    <= step_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH 8, 4 and 16.
// Expected products come from hand-computed constants or an integer multiply model.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, s8 = 0, ov8, or8 = 0, busy8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;

    logic        iv4 = 0, ir4, s4 = 0, ov4, or4 = 0, busy4;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  p4;

    logic        iv16 = 0, ir16, s16 = 0, ov16, or16 = 0, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );
    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
    );
    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint model(input logic [15:0] x, input logic [15:0] y,
                                     input logic s, input int w);
        longint ex, ey, r;
        ex = longint'(x);
        ey = longint'(y);
        if (s && x[w-1]) ex = ex - (longint'(1) << w);
        if (s && y[w-1]) ey = ey - (longint'(1) << w);
        r = ex * ey;
        return r & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ir=%b ov=%b busy=%b p=%h, want 1 0 0 0000", ir8, ov8, busy8, p8);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (ir8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ir=%b busy=%b, want 1 0", ir8, busy8);
        end
    endtask

    task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        int t;
        a8 = ta; b8 = tb; s8 = ts; iv8 = 1'b1;
        t = 0;
        while (!ir8 && t < 50) begin tick; t++; end
        tick;
        iv8 = 1'b0;
        a8 = ~ta; b8 = ~tb; s8 = ~ts;
        checks++;
        if (ir8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL accept: ir=%b busy=%b, want 0 1", ir8, busy8);
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!ov8 && lat < 50) begin tick; lat++; end
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                           input logic [15:0] exp, input string name);
        int lat;
        start_op8(ta, tb, ts);
        wait_done8(lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, want 5", name, lat);
        end
        checks++;
        if (p8 !== exp) begin
            errors++;
            $display("FAIL %s_product: got %h, want %h", name, p8, exp);
        end
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || p8 !== exp) begin
            errors++;
            $display("FAIL %s_handshake: ov=%b ir=%b p=%h, want 0 1 %h", name, ov8, ir8, p8, exp);
        end
    endtask

    task automatic test_directed;
        run_op8(8'h80, 8'h80, 1'b1, 16'h4000, "neg128_sq");
        run_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ff_unsigned");
        run_op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "ff_signed");
        run_op8(8'h7F, 8'hFF, 1'b1, 16'hFF81, "127_x_m1");
        run_op8(8'h00, 8'h80, 1'b1, 16'h0000, "zero_x_m128");
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        start_op8(8'd3, 8'd5, 1'b0);
        wait_done8(lat);
        a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (ov8 !== 1'b1 || p8 !== 16'd15 || ir8 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles, want 0 (last ov=%b p=%h ir=%b)", bad, ov8, p8, ir8);
        end
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        iv8 = 1'b0;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0 || p8 !== 16'd15) begin
            errors++;
            $display("FAIL backpressure_release: ov=%b ir=%b busy=%b p=%h, want 0 1 0 000f", ov8, ir8, busy8, p8);
        end
    endtask

    task automatic test_reset_mid_calc;
        start_op8(8'd100, 8'd100, 1'b1);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_abort: ov=%b busy=%b ir=%b p=%h, want 0 0 1 0000", ov8, busy8, ir8, p8);
        end
        run_op8(8'd3, 8'hFB, 1'b1, 16'hFFF1, "after_reset");
    endtask

    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        a8 = 8'd2; b8 = 8'd3; s8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (ov8) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        checks++;
        if (first < 0 || second - first != 7) begin
            errors++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, want spacing 7", first, second);
        end
        checks++;
        if (p8 !== 16'd6) begin
            errors++;
            $display("FAIL b2b_product: got %h, want 0006", p8);
        end
        iv8 = 1'b0;
        repeat (10) tick;
        or8 = 1'b0;
    endtask

    task automatic test_random_w4;
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ra, rb;
            logic       rs;
            logic [7:0] exp;
            longint     m;
            int         t;
            ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
            m = model({12'h0, ra}, {12'h0, rb}, rs, 4);
            exp = m[7:0];
            repeat ($urandom_range(0, 2)) tick;
            a4 = ra; b4 = rb; s4 = rs; iv4 = 1'b1;
            t = 0;
            while (!ir4 && t < 50) begin tick; t++; end
            tick;
            iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
            t = 0;
            while (!ov4 && t < 50) begin tick; t++; end
            repeat ($urandom_range(0, 2)) tick;
            checks++;
            if (ov4 !== 1'b1 || p4 !== exp) begin
                errors++;
                $display("FAIL w4_op%0d: ov=%b p=%h, want 1 %h (a=%h b=%h s=%b)", i, ov4, p4, exp, ra, rb, rs);
            end
            or4 = 1'b1;
            tick;
            or4 = 1'b0;
            checks++;
            if (ov4 !== 1'b0) begin
                errors++;
                $display("FAIL w4_dup%0d: ov=%b after handshake, want 0", i, ov4);
            end
        end
    endtask

    task automatic test_random_w16;
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            logic [31:0] exp;
            longint      m;
            int          t;
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            m = model(ra, rb, rs, 16);
            exp = m[31:0];
            repeat ($urandom_range(0, 2)) tick;
            a16 = ra; b16 = rb; s16 = rs; iv16 = 1'b1;
            t = 0;
            while (!ir16 && t < 50) begin tick; t++; end
            tick;
            iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
            t = 0;
            while (!ov16 && t < 50) begin tick; t++; end
            repeat ($urandom_range(0, 2)) tick;
            checks++;
            if (ov16 !== 1'b1 || p16 !== exp) begin
                errors++;
                $display("FAIL w16_op%0d: ov=%b p=%h, want 1 %h (a=%h b=%h s=%b)", i, ov16, p16, exp, ra, rb, rs);
            end
            or16 = 1'b1;
            tick;
            or16 = 1'b0;
            checks++;
            if (ov16 !== 1'b0) begin
                errors++;
                $display("FAIL w16_dup%0d: ov=%b after handshake, want 0", i, ov16);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_calc;
        test_back_to_back;
        test_random_w4;
        test_random_w16;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised, iterative radix-4 Booth multiplier with valid/ready handshakes on input and output, and a per-operation signed/unsigned mode. It sits in the multiplier algorithm library as the clocked successor of the combinational radix-2 Booth unit. It retires two multiplier bits per cycle and holds its result until the consumer takes it. It is intended for datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 8, operand width in bits; must be even and at least 4.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands; sampled with a and b.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, full-width, interpreted per latched mode.
- busy  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, product 0.
  - Internal accumulator, step counter and latched mode are cleared.
- IDLE: on in_valid && in_ready, capture a, b and is_signed, then go to CALC with step = 0.
- Operand extension at capture:
  - a and b are extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Appended bit q[-1] = 0.
- Number of steps: N = WIDTH/2 + 1. For WIDTH=8, N=5.
- Each CALC step examines the multiplier triplet {q1, q0, q-1}:
  - 000 or 111: +0
  - 001 or 010: +M
  - 011: +2M
  - 100: -2M
  - 101 or 110: -M
- The addend is added to the upper accumulator, which is WIDTH+4 bits wide so that ±2M never overflows.
- After each add, the combined {accumulator, multiplier, q-1} register is arithmetic-shifted right by 2.
- After step N-1 completes, state goes to DONE.
  - product = low 2*WIDTH bits of the final {accumulator, multiplier} register.
  - This is exact for both modes across the full operand range.
- DONE:
  - product and out_valid are held stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE. out_valid drops and product keeps its last value.
- Inputs are ignored outside IDLE. a, b and is_signed may change freely once accepted.
- rst has priority over every transition. Asserting it in CALC or DONE aborts the operation, and the result is discarded.

## Timing
- Accept edge = edge 0. CALC steps execute on edges 1..N. out_valid is high in the cycle after edge N.
  - For WIDTH=8, out_valid is first high 5 edges after the accept edge.
- There is no combinational path from in_valid or out_ready to any output. All outputs are registered or decoded from state.
- in_ready is low from the cycle after the accept edge until the cycle after the output handshake edge.
- Back-to-back throughput: one operation per N+2 cycles when out_ready is held high.
- Reset: asserting rst at any edge puts all outputs at their reset values in the following cycle. in_ready is 1 in the first cycle after rst deasserts.
- Simultaneous events:
  - in_valid asserted during DONE has no effect.
  - An output handshake and a new input in the same cycle are not overlapped; the new input waits for IDLE.

## Test plan
- WIDTH=8 signed, a=-128, b=-128 -> product 16'h4000 (16384), out_valid 5 edges after accept.
- WIDTH=8 unsigned, a=8'hFF, b=8'hFF -> product 16'hFE01 (65025). The same bits with is_signed=1 -> 16'h0001.
- WIDTH=8 signed, a=127, b=-1 -> 16'hFF81. a=0, b=-128 -> 16'h0000.
- Backpressure: hold out_ready low for 10 cycles in DONE -> out_valid stays 1, product stays stable, in_ready stays 0. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Reset after the 2nd CALC step -> next cycle out_valid=0, busy=0, in_ready=1, product=0. A following op of 3*-5 signed -> 16'hFFF1.
- WIDTH=16 and WIDTH=4, random 2000 ops each with mixed mode and random in_valid/out_ready gaps -> every product matches the bench model, with no dropped or duplicated transactions.
